dm_arbiter: RTL
===============

Name: dm_arbiter

Overview:
- Shares the single-port, word-wide data memory (DM) between two requesters: M0, the CPU MEM stage, and M1, the loader/debug master.
- Arbitrates between them, sequences each access through a small FSM, and registers the read data.
- DM has no byte enables, so partial-word stores (sb/sh) are done as read-modify-write (RMW).
- Sits between the requesters and DM; DM read data is combinational from its address, and DM writes happen on the clock edge.

Parameters:
RR_EN, 1, 1 = round-robin between M0 and M1; 0 = fixed priority, M0 always wins.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
m0_req  in  1  M0 request; held stable until m0_ack
m0_we  in  1  M0 write (1) / read (0)
m0_be  in  4  M0 byte enables (writes only)
m0_addr  in  32  M0 byte address
m0_wdata  in  32  M0 write data, in byte lanes
m0_pc  in  32  M0 PC tag, forwarded to DM for its write log
m0_ack  out  1  one-cycle completion pulse to M0
m0_rdata  out  32  M0 read data; valid while m0_ack=1
m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_pc, m1_ack, m1_rdata  (same as M0, for M1)
mem_we  out  1  DM write strobe
mem_addr  out  32  DM address, word-aligned
mem_wd  out  32  DM write data
mem_pc  out  32  PC tag of the current access
mem_rdata  in  32  DM combinational read data
busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values: state=IDLE, last=1 (so M0 wins the first tie), mem_we=0, mem_addr=0, mem_wd=0, mem_pc=0, both acks=0, both rdata=0, busy=0.
- While reset=1: no mem_we, no ack, FSM returns to IDLE. An access interrupted by reset is dropped and never acked; in-flight RMW data is discarded.
- States and transitions:
  - IDLE: sample requests.
    - No request: stay in IDLE.
    - Otherwise pick a winner, latch its we/be/addr/wdata/pc and the winner id.
    - Next state: ACC if the access is a read, a write with be=4'b1111, or a write with be=4'b0000. RMW_RD if it is a partial write.
  - ACC:
    - Read: drive mem_addr; latch mem_rdata into the winner's rdata register.
    - Write with be=1111: assert mem_we=1 with mem_wd=wdata.
    - Write with be=0000: no mem_we; completes as a no-op.
    - Next state: RESP.
  - RMW_RD: drive mem_addr with mem_we=0. Register merged = per byte lane i, be[i] ? wdata lane i : mem_rdata lane i. Next state: RMW_WR.
  - RMW_WR: mem_we=1, mem_wd=merged. Next state: RESP.
  - RESP: winner's ack=1 for exactly this cycle. Next state: IDLE.
- Latency from the IDLE sampling cycle (N) to the ack cycle:
  - Read or full-word write: ack in N+2.
  - Partial write: ack in N+3.
  - Minimum spacing between accepted requests: 3 cycles (reads/full writes), 4 cycles (partial writes).
- Arbitration:
  - Only one requester: it wins.
  - Both request, RR_EN=1: grant the one that is not `last`; update last=winner on grant.
  - Both request, RR_EN=0: M0 wins.
  - A loser is never acked; it keeps req high and is served later.
- Handshake:
  - Requester holds req and its inputs stable until it sees ack.
  - It may drop req or present a new request from the cycle after ack.
  - Inputs are sampled only in IDLE; later changes are ignored.
- Address and data:
  - mem_addr = {addr[31:2], 2'b00}; addr[1:0] is ignored, no misalignment check.
  - Reads always return the full 32-bit word; be is ignored; lane extraction belongs to the requester.
  - The rdata register holds its value until the next read by the same master.
- mem_addr and mem_pc hold their last value outside ACC/RMW states; mem_we=0 outside ACC (full-word write) and RMW_WR.
- A read by the other master cannot interleave between RMW_RD and RMW_WR, so RMW is atomic.

Test Plan:
1. Single read: DM word 0x10 = 0x12345678; M0 read addr 0x13. Expect mem_addr=0x10, no mem_we, m0_ack in N+2, m0_rdata=0x12345678.
2. Full-word write: M1 write addr 0x20, be=1111, wdata=0xDEADBEEF, pc=0x3000. Expect exactly one mem_we cycle with mem_wd=0xDEADBEEF, mem_pc=0x3000; m1_ack in N+2; a following read returns 0xDEADBEEF.
3. Partial write (sb): DM word 0x40 = 0x11223344; M0 write be=0100, wdata=0x00AB0000. Expect mem_we only in RMW_WR with mem_wd=0x11AB3344; m0_ack in N+3.
4. Contention, RR_EN=1: both request continuously after reset. Grants go M0, M1, M0, M1; acks never overlap; losing req stays high and is never dropped. RR_EN=0: every grant goes to M0.
5. be=0000 write: ack in N+2, mem_we never asserted, memory unchanged.
6. Reset mid-RMW: assert reset in the RMW_RD cycle. Expect no mem_we and no ack; FSM in IDLE, all outputs at reset values; memory word unchanged; the still-held req is re-served after reset.

Source files
------------

// File: rtl/dm_arbiter_if.sv
// Requester-side (M0/M1) and data-memory-side signals of the DM arbiter.
interface dm_arbiter_if;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          m0_req;
  logic          m0_we;
  logic [BW-1:0] m0_be;
  logic [DW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic [DW-1:0] m0_pc;
  logic          m0_ack;
  logic [DW-1:0] m0_rdata;

  logic          m1_req;
  logic          m1_we;
  logic [BW-1:0] m1_be;
  logic [DW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic [DW-1:0] m1_pc;
  logic          m1_ack;
  logic [DW-1:0] m1_rdata;

  logic          mem_we;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_pc;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  modport slave (
    input  m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_pc,
    output m0_ack, m0_rdata,
    input  m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_pc,
    output m1_ack, m1_rdata,
    output mem_we, mem_addr, mem_wd, mem_pc,
    input  mem_rdata,
    output busy
  );

  modport master (
    output m0_req, m0_we, m0_be, m0_addr, m0_wdata, m0_pc,
    input  m0_ack, m0_rdata,
    output m1_req, m1_we, m1_be, m1_addr, m1_wdata, m1_pc,
    input  m1_ack, m1_rdata,
    input  mem_we, mem_addr, mem_wd, mem_pc,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port data memory; partial-word stores
// are performed as an atomic read-modify-write.
module dm_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input logic         clk,
  input logic         reset,
  dm_arbiter_if.slave bus
);
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  typedef enum logic [2:0] {IDLE, ACC, RMW_RD, RMW_WR, RESP} state_t;

  state_t        state_q, state_d;
  logic          last_q, last_d;   // 1: M1 was granted most recently
  logic          sel_q, sel_d;     // 1: M1 owns the current access
  logic          we_q, we_d;
  logic [BW-1:0] be_q, be_d;
  logic [DW-1:0] wdata_q, wdata_d;

  logic          mem_we_q, mem_we_d;
  logic [DW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wd_q, mem_wd_d;
  logic [DW-1:0] mem_pc_q, mem_pc_d;
  logic          m0_ack_q, m0_ack_d;
  logic          m1_ack_q, m1_ack_d;
  logic [DW-1:0] m0_rdata_q, m0_rdata_d;
  logic [DW-1:0] m1_rdata_q, m1_rdata_d;
  logic          busy_q, busy_d;

  logic          grant_m1;
  logic          req_we;
  logic [BW-1:0] req_be;
  logic [DW-1:0] req_addr, req_wdata, req_pc;
  logic [DW-1:0] merged;

  // Winner selection, request mux and byte-lane merge for RMW
  always_comb begin
    grant_m1 = 1'b0;
    if (bus.m0_req && bus.m1_req) begin
      grant_m1 = RR_EN ? ~last_q : 1'b0;
    end else begin
      grant_m1 = bus.m1_req;
    end
    req_we    = grant_m1 ? bus.m1_we    : bus.m0_we;
    req_be    = grant_m1 ? bus.m1_be    : bus.m0_be;
    req_addr  = grant_m1 ? bus.m1_addr  : bus.m0_addr;
    req_wdata = grant_m1 ? bus.m1_wdata : bus.m0_wdata;
    req_pc    = grant_m1 ? bus.m1_pc    : bus.m0_pc;

    merged = bus.mem_rdata;
    for (int unsigned i = 0; i < BW; i++) begin
      if (be_q[i]) merged[8*i +: 8] = wdata_q[8*i +: 8];
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    sel_d      = sel_q;
    we_d       = we_q;
    be_d       = be_q;
    wdata_d    = wdata_q;
    mem_we_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_wd_d   = mem_wd_q;
    mem_pc_d   = mem_pc_q;
    m0_ack_d   = 1'b0;
    m1_ack_d   = 1'b0;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.m0_req || bus.m1_req) begin
          sel_d      = grant_m1;
          last_d     = grant_m1;
          we_d       = req_we;
          be_d       = req_be;
          wdata_d    = req_wdata;
          mem_addr_d = req_addr & ~DW'(3);
          mem_pc_d   = req_pc;
          if (req_we && (req_be == '1)) begin
            mem_we_d = 1'b1;
            mem_wd_d = req_wdata;
          end
          if (req_we && (req_be != '0) && (req_be != '1)) begin
            state_d = RMW_RD;
          end else begin
            state_d = ACC;
          end
        end
      end
      ACC: begin
        if (!we_q) begin
          if (sel_q) m1_rdata_d = bus.mem_rdata;
          else       m0_rdata_d = bus.mem_rdata;
        end
        m0_ack_d = ~sel_q;
        m1_ack_d = sel_q;
        state_d  = RESP;
      end
      RMW_RD: begin
        mem_we_d = 1'b1;
        mem_wd_d = merged;
        state_d  = RMW_WR;
      end
      RMW_WR: begin
        m0_ack_d = ~sel_q;
        m1_ack_d = sel_q;
        state_d  = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      last_q     <= 1'b1;
      sel_q      <= 1'b0;
      we_q       <= 1'b0;
      be_q       <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_wd_q   <= '0;
      mem_pc_q   <= '0;
      m0_ack_q   <= 1'b0;
      m1_ack_q   <= 1'b0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      sel_q      <= sel_d;
      we_q       <= we_d;
      be_q       <= be_d;
      wdata_q    <= wdata_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      mem_pc_q   <= mem_pc_d;
      m0_ack_q   <= m0_ack_d;
      m1_ack_q   <= m1_ack_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.mem_we   = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wd   = mem_wd_q;
  assign bus.mem_pc   = mem_pc_q;
  assign bus.m0_ack   = m0_ack_q;
  assign bus.m1_ack   = m1_ack_q;
  assign bus.m0_rdata = m0_rdata_q;
  assign bus.m1_rdata = m1_rdata_q;
  assign bus.busy     = busy_q;

endmodule
